// File: rtl/div_unit.sv
// Signed 32-bit sequential divider: restoring shift-subtract on magnitudes,
// one quotient bit per cycle, results in hi (remainder) and lo (quotient).
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] divisor;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [5:0]  count;
    logic        q_neg;
    logic        r_neg;
    logic        dz_pend;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] rem_shift;
    logic [32:0] trial;
    logic        calc_last;
    logic        b_is_zero;

    // rem < divisor <= 2^31 keeps rem_shift below 2^32, so trial[32] is a pure borrow.
    always_comb begin
        a_mag     = a[31] ? (~a + 32'd1) : a;
        b_mag     = b[31] ? (~b + 32'd1) : b;
        rem_shift = {rem, quot[31]};
        trial     = rem_shift - {1'b0, divisor};
        calc_last = (count == 6'd32);
        b_is_zero = (b == 32'd0);
    end

    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = b_is_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (calc_last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            divisor <= 32'd0;
            quot    <= 32'd0;
            rem     <= 32'd0;
            count   <= 6'd0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            dz_pend <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b_is_zero) begin
                            dz_pend <= 1'b1;
                        end else begin
                            dz_pend <= 1'b0;
                            divisor <= b_mag;
                            quot    <= a_mag;
                            rem     <= 32'd0;
                            count   <= 6'd0;
                            q_neg   <= a[31] ^ b[31];
                            r_neg   <= a[31];
                        end
                    end
                end
                CALC: begin
                    if (calc_last) begin
                        lo <= q_neg ? (~quot + 32'd1) : quot;
                        hi <= r_neg ? (~rem + 32'd1) : rem;
                    end else begin
                        count <= count + 6'd1;
                        if (!trial[32]) begin
                            rem  <= trial[31:0];
                            quot <= {quot[30:0], 1'b1};
                        end else begin
                            rem  <= rem_shift[31:0];
                            quot <= {quot[30:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state == CALC);
    assign done     = (state == DONE);
    assign div_zero = (state == DONE) && dz_pend;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: signed results, divide-by-zero,
// overflow case, ignored restarts, mid-calculation reset and latency.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Issues one division and follows it to completion. exp_edge is the number
    // of edges after the start-sampling edge at which done appears (33 or 0).
    // inject_at > 0 pulses a competing start (9/3) on that edge, which must be ignored.
    task automatic run_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input logic exp_dz, input int exp_edge, input int inject_at);
        int   k;
        logic busy_bad;
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        k        = 0;
        busy_bad = 1'b0;
        while (!done && k < 50) begin
            if (busy !== (exp_edge != 0)) busy_bad = 1'b1;
            if (k + 1 == inject_at) begin
                start = 1'b1;
                a     = 32'd9;
                b     = 32'd3;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            k++;
        end
        check({tag, "_latency"}, k, exp_edge);
        check({tag, "_busy_during"}, {31'd0, busy_bad}, 32'd0);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, exp_dz});
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_hi"}, hi, exp_hi);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        check({tag, "_dz_one_cycle"}, {31'd0, div_zero}, 32'd0);
    endtask

    initial begin
        int seen_done;
        int seen_busy;

        reset = 1'b0;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        #3;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_div_zero", {31'd0, div_zero}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        run_div("d7_2",     32'd7,        32'd2,        32'h0000_0003, 32'h0000_0001, 1'b0, 33, 0);
        run_div("div0",     32'd5,        32'd0,        32'h0000_0003, 32'h0000_0001, 1'b1, 0,  0);
        run_div("dm7_2",    32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 0);
        run_div("d7_m2",    32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 33, 0);
        run_div("dm7_m2",   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0, 33, 0);
        run_div("ovf",      32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 33, 0);
        run_div("dmax_1",   32'h7FFF_FFFF, 32'd1,       32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 33, 0);
        run_div("dm1_min",  32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 33, 0);
        run_div("d0_5",     32'd0,        32'd5,        32'h0000_0000, 32'h0000_0000, 1'b0, 33, 0);
        run_div("restart",  32'd100,      32'd7,        32'd14,        32'd2,         1'b0, 33, 5);

        // Abort a division with an asynchronous reset ten edges in.
        @(negedge clk);
        start = 1'b1;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_div_zero", {31'd0, div_zero}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen_done = 0;
        seen_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
            if (busy) seen_busy++;
        end
        check("abort_no_done", seen_done, 0);
        check("abort_no_busy", seen_busy, 0);

        run_div("post_rst", 32'd100,      32'd7,        32'd14,        32'd2,         1'b0, 33, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
